dma_priority_arbiter: RTL and testbench

Upstream arbitration stage of the 8237A-style DMA controller. It samples the four DREQ lines and software request bits, applies mask, polarity and controller-disable settings, and selects one channel by fixed or rotating priority. It presents that channel to the timing control FSM as a one-hot valid request, holds the grant for the whole service, and drives the DACK pins while the timing control asserts `validDACK`.

---
 rtl/dma_priority_arbiter.sv | 157 +++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - DREQ/software request arbitration and DACK drive for a 4-channel DMA
//
// Optional feature macro: DMA_ROTATING_PRIORITY_EN
//   defined   : commandReg[4] selects rotating priority and the `last` pointer exists
//   undefined : fixed priority only (ch0 highest), commandReg[4] ignored
//
// Ports:
//   CLK         in   1  controller clock
//   RESET_N     in   1  asynchronous active-low reset
//   DREQ        in   4  external request pins, sense set by commandReg[6]
//   commandReg  in   8  [2] disable, [4] rotating, [6] DREQ active-low, [7] DACK active-high
//   maskReg     in   4  1 masks the hardware DREQ of that channel
//   requestReg  in   4  software requests, never masked
//   HLDA        in   1  hold acknowledge from the CPU
//   validDACK   in   1  timing control wants DACK active for the granted channel
//   svcDone     in   1  one-cycle end-of-service pulse from timing control
//   EOP_N       in   1  end of process, active-low
//   VALID_DREQ  out  4  one-hot granted channel, 0 when no grant
//   DACK        out  4  acknowledge pins, polarity per commandReg[7]
//   grantCh     out  2  encoded granted channel, valid while busy
//   busy        out  1  high in GRANT and ACTIVE

module dma_priority_arbiter (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] DREQ,
  input  logic [7:0] commandReg,
  input  logic [3:0] maskReg,
  input  logic [3:0] requestReg,
  input  logic       HLDA,
  input  logic       validDACK,
  input  logic       svcDone,
  input  logic       EOP_N,
  output logic [3:0] VALID_DREQ,
  output logic [3:0] DACK,
  output logic [1:0] grantCh,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACTIVE = 2'd2
  } arbState;

  arbState    state;
  arbState    nextState;
  logic [3:0] reqComb;
  logic [3:0] reqQ;
  logic [3:0] dackRaw;
  logic [1:0] startPtr;
  logic [1:0] winner;

  // Effective request; the disable bit suppresses everything, software bits included.
  always_comb begin
    reqComb = 4'b0000;
    if (!commandReg[2]) begin
      reqComb = ((DREQ ^ {4{commandReg[6]}}) & ~maskReg) | requestReg;
    end
  end

`ifdef DMA_ROTATING_PRIORITY_EN
  // Lowest-priority channel; reset to 3 so the first scan begins at ch0.
  logic [1:0] last;
  logic       releaseSvc;

  // Only a normal end of service rotates; an HLDA abort leaves the pointer alone.
  assign releaseSvc = (state == ACTIVE) && HLDA && (svcDone || !EOP_N);
  assign startPtr   = commandReg[4] ? last : 2'd3;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last <= 2'd3;
    end else if (releaseSvc && commandReg[4]) begin
      last <= grantCh;
    end
  end

  logic unusedBits;
  assign unusedBits = ^{commandReg[5], commandReg[3], commandReg[1:0]};
`else
  // Fixed order is the rotating scan frozen with the pointer at ch3.
  assign startPtr = 2'd3;

  logic unusedBits;
  assign unusedBits = ^{commandReg[5:3], commandReg[1:0]};
`endif

  // Scan startPtr+1 .. startPtr+4; iterating downward lets the nearest hit win.
  always_comb begin
    winner = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      if (reqQ[startPtr + 2'(i)]) begin
        winner = startPtr + 2'(i);
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (reqQ != 4'b0000) begin
          nextState = GRANT;
        end
      end
      GRANT: begin
        // HLDA wins over a same-cycle withdrawal; the disable bit acts at once.
        if (HLDA) begin
          nextState = ACTIVE;
        end else if (!reqQ[grantCh] || commandReg[2]) begin
          nextState = IDLE;
        end
      end
      ACTIVE: begin
        if (!HLDA) begin
          nextState = IDLE;
        end else if (svcDone || !EOP_N) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      reqQ       <= 4'b0000;
      VALID_DREQ <= 4'b0000;
      grantCh    <= 2'd0;
      dackRaw    <= 4'b0000;
    end else begin
      state <= nextState;
      reqQ  <= reqComb;
      if ((state == IDLE) && (nextState == GRANT)) begin
        grantCh    <= winner;
        VALID_DREQ <= 4'(1) << winner;
      end else if (nextState == IDLE) begin
        VALID_DREQ <= 4'b0000;
      end
      // Cleared on the release edge itself so DACK never outlives the grant.
      if ((state == ACTIVE) && (nextState == ACTIVE) && validDACK) begin
        dackRaw <= 4'(1) << grantCh;
      end else begin
        dackRaw <= 4'b0000;
      end
    end
  end

  assign busy = (state != IDLE);
  assign DACK = commandReg[7] ? dackRaw : ~dackRaw;

  dackOneHot: assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(dackRaw));
  validOneHot: assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(VALID_DREQ));

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb/tb_dma_priority_arbiter.sv - scoreboard bench for dma_priority_arbiter
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic [7:0] commandReg;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic       HLDA;
  logic       validDACK;
  logic       svcDone;
  logic       EOP_N;
  logic [3:0] VALID_DREQ;
  logic [3:0] DACK;
  logic [1:0] grantCh;
  logic       busy;

  int         vectors;
  int         miscompares;
  logic [1:0] expQ[$];

  dma_priority_arbiter dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .DREQ       (DREQ),
    .commandReg (commandReg),
    .maskReg    (maskReg),
    .requestReg (requestReg),
    .HLDA       (HLDA),
    .validDACK  (validDACK),
    .svcDone    (svcDone),
    .EOP_N      (EOP_N),
    .VALID_DREQ (VALID_DREQ),
    .DACK       (DACK),
    .grantCh    (grantCh),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic waitBusy(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_grantTimeout busy=%b required 1", tag, busy);
    end
  endtask

  // Pops the expected channel, checks the grant, then runs HLDA/DACK/svcDone.
  task automatic serviceExpected(input string tag, input logic [3:0] nextDreq,
                                 input logic [3:0] nextReq);
    logic [1:0] expCh;
    logic [3:0] expOne;
    logic [3:0] dackOn;
    logic [3:0] dackOff;
    waitBusy(tag);
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("FAIL %s_queue empty scoreboard, grantCh=%0d", tag, grantCh);
      expCh = 2'd0;
    end else begin
      expCh = expQ.pop_front();
    end
    expOne = 4'b0001 << expCh;
    vectors++;
    if (VALID_DREQ !== expOne) begin
      miscompares++;
      $display("FAIL %s_validDreq got=%b required=%b", tag, VALID_DREQ, expOne);
    end
    vectors++;
    if (grantCh !== expCh) begin
      miscompares++;
      $display("FAIL %s_grantCh got=%0d required=%0d", tag, grantCh, expCh);
    end
    HLDA = 1'b1;
    @(negedge CLK);
    validDACK = 1'b1;
    @(negedge CLK);
    dackOn  = commandReg[7] ? expOne : ~expOne;
    dackOff = commandReg[7] ? 4'b0000 : 4'b1111;
    vectors++;
    if (DACK !== dackOn) begin
      miscompares++;
      $display("FAIL %s_dackActive got=%b required=%b", tag, DACK, dackOn);
    end
    validDACK  = 1'b0;
    svcDone    = 1'b1;
    DREQ       = nextDreq;
    requestReg = nextReq;
    @(negedge CLK);
    vectors++;
    if (busy !== 1'b0 || VALID_DREQ !== 4'b0000 || DACK !== dackOff) begin
      miscompares++;
      $display("FAIL %s_release busy=%b valid=%b dack=%b required 0 0000 %b",
               tag, busy, VALID_DREQ, DACK, dackOff);
    end
    svcDone = 1'b0;
    HLDA    = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    DREQ = 4'b0000; commandReg = 8'h00; maskReg = 4'b0000; requestReg = 4'b0000;
    HLDA = 1'b0; validDACK = 1'b0; svcDone = 1'b0; EOP_N = 1'b1;
    #1;
    vectors++;
    if (VALID_DREQ !== 4'b0000 || busy !== 1'b0 || grantCh !== 2'd0 || DACK !== 4'b1111) begin
      miscompares++;
      $display("FAIL reset valid=%b busy=%b grant=%0d dack=%b required 0000 0 0 1111",
               VALID_DREQ, busy, grantCh, DACK);
    end
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_fixed();
    commandReg = 8'h00;
    DREQ = 4'b1010;
    expQ.push_back(2'd1);
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (VALID_DREQ !== 4'b0010) begin
      miscompares++;
      $display("FAIL fixed_latency got=%b required=0010", VALID_DREQ);
    end
    serviceExpected("fixed1", 4'b1000, 4'b0000);
    expQ.push_back(2'd3);
    serviceExpected("fixed3", 4'b0000, 4'b0000);
  endtask

  task automatic test_rotating();
    commandReg = 8'h10;
`ifdef DMA_ROTATING_PRIORITY_EN
    DREQ = 4'b0010;
    expQ.push_back(2'd1);
    serviceExpected("rotSeed", 4'b1111, 4'b0000);
    expQ.push_back(2'd2);
    expQ.push_back(2'd3);
    expQ.push_back(2'd0);
    expQ.push_back(2'd1);
    serviceExpected("rot2", 4'b1111, 4'b0000);
    serviceExpected("rot3", 4'b1111, 4'b0000);
    serviceExpected("rot0", 4'b1111, 4'b0000);
    serviceExpected("rot1", 4'b0000, 4'b0000);
`else
    DREQ = 4'b1111;
    for (int i = 0; i < 3; i++) expQ.push_back(2'd0);
    serviceExpected("rotIgnoredA", 4'b1111, 4'b0000);
    serviceExpected("rotIgnoredB", 4'b1111, 4'b0000);
    serviceExpected("rotIgnoredC", 4'b0000, 4'b0000);
`endif
    commandReg = 8'h00;
  endtask

  task automatic test_mask_softreq();
    maskReg = 4'b0001;
    DREQ = 4'b0001;
    requestReg = 4'b0000;
    repeat (4) @(negedge CLK);
    vectors++;
    if (busy !== 1'b0 || VALID_DREQ !== 4'b0000) begin
      miscompares++;
      $display("FAIL mask_blocks busy=%b valid=%b required 0 0000", busy, VALID_DREQ);
    end
    requestReg = 4'b0001;
    expQ.push_back(2'd0);
    serviceExpected("softReq", 4'b0000, 4'b0000);
    maskReg = 4'b0000;
  endtask

  task automatic test_polarity();
    commandReg = 8'hC0;
    DREQ = 4'b1011;
    expQ.push_back(2'd2);
    serviceExpected("polarity", 4'b1111, 4'b0000);
    @(negedge CLK);
    vectors++;
    if (DACK !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL polarity_idle dack=%b busy=%b required 0000 0", DACK, busy);
    end
    commandReg = 8'h00;
    DREQ = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_cancel();
    DREQ = 4'b0100;
    waitBusy("cancel");
    vectors++;
    if (VALID_DREQ !== 4'b0100) begin
      miscompares++;
      $display("FAIL cancel_grant got=%b required=0100", VALID_DREQ);
    end
    DREQ = 4'b0000;
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (VALID_DREQ !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_drop valid=%b busy=%b required 0000 0", VALID_DREQ, busy);
    end
    DREQ = 4'b0100;
    waitBusy("disable");
    commandReg = 8'h04;
    DREQ = 4'b0000;
    @(negedge CLK);
    vectors++;
    if (VALID_DREQ !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_cancel valid=%b busy=%b required 0000 0", VALID_DREQ, busy);
    end
    commandReg = 8'h00;
    @(negedge CLK);
  endtask

  task automatic test_abort();
    commandReg = 8'h10;
    DREQ = 4'b0001;
    waitBusy("abort");
    vectors++;
    if (grantCh !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_grant got=%0d required=0", grantCh);
    end
    HLDA = 1'b1;
    @(negedge CLK);
    DREQ = 4'b0000;
    HLDA = 1'b0;
    @(negedge CLK);
    vectors++;
    if (busy !== 1'b0 || VALID_DREQ !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_idle busy=%b valid=%b required 0 0000", busy, VALID_DREQ);
    end
    DREQ = 4'b1111;
`ifdef DMA_ROTATING_PRIORITY_EN
    expQ.push_back(2'd2);
`else
    expQ.push_back(2'd0);
`endif
    serviceExpected("abortLast", 4'b0000, 4'b0000);
    commandReg = 8'h00;
  endtask

  task automatic test_eop();
    DREQ = 4'b1000;
    waitBusy("eop");
    HLDA = 1'b1;
    @(negedge CLK);
    EOP_N = 1'b0;
    DREQ = 4'b0000;
    @(negedge CLK);
    vectors++;
    if (busy !== 1'b0 || VALID_DREQ !== 4'b0000) begin
      miscompares++;
      $display("FAIL eop_release busy=%b valid=%b required 0 0000", busy, VALID_DREQ);
    end
    EOP_N = 1'b1;
    HLDA = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_async_reset();
    DREQ = 4'b0010;
    waitBusy("asyncReset");
    HLDA = 1'b1;
    @(negedge CLK);
    validDACK = 1'b1;
    @(negedge CLK);
    vectors++;
    if (DACK !== 4'b1101) begin
      miscompares++;
      $display("FAIL async_dackBefore got=%b required=1101", DACK);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    vectors++;
    if (VALID_DREQ !== 4'b0000 || DACK !== 4'b1111 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset valid=%b dack=%b busy=%b required 0000 1111 0",
               VALID_DREQ, DACK, busy);
    end
    DREQ = 4'b0000;
    HLDA = 1'b0;
    validDACK = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fixed();
    test_rotating();
    test_mask_softreq();
    test_polarity();
    test_cancel();
    test_abort();
    test_eop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
